// File: rtl/retire_perf_monitor.sv
// Retire performance monitor: cycle and retired-instruction counters from start_i to CSRRW completion, optional dual-issue counter (RETIRE_MON_DUAL_CNT_EN).
// rd_data_o is registered with one cycle of latency; there is no backpressure, so inputs are sampled every cycle.
module retire_perf_monitor #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DRAIN_CYCLES   = 10,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             retire0_i,
  input  logic             retire1_i,
  input  logic             csr_wr_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int unsigned TW    = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(DRAIN_CYCLES);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_e;

  state_e           state_q, state_d;
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] dual_cnt;
  logic [CNT_W:0]   instr_sum;
  logic             clr_cnt;
  logic             cnt_en;
  logic             timeout_hit;

  assign cnt_en      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign timeout_hit = (TW'(cycle_q) == TO_LAST);
  assign instr_sum   = {1'b0, instr_q} + {{CNT_W{1'b0}}, retire0_i} + {{CNT_W{1'b0}}, retire1_i};

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    clr_cnt = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (start_i) begin
          state_d = S_RUN;
          clr_cnt = 1'b1;
        end
      end
      S_RUN: begin
        // Completion beats a coincident timeout.
        if (csr_wr_i) begin
          state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          drain_d = DRN_INIT;
        end else if (timeout_hit) begin
          state_d = S_TIMEOUT;
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRN_W'(1);
        if (drain_q <= DRN_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (clr_cnt) begin
      cycle_d = '0;
      instr_d = '0;
    end else if (cnt_en) begin
      if (cycle_q != CNT_MAX) cycle_d = cycle_q + CNT_W'(1);
      instr_d = instr_sum[CNT_W] ? CNT_MAX : instr_sum[CNT_W-1:0];
    end
  end

  always_comb begin
    rd_d = '0;
    case (rd_sel_i)
      2'd0:    rd_d = cycle_q;
      2'd1:    rd_d = instr_q;
      2'd2:    rd_d = dual_cnt;
      default: rd_d = {{(CNT_W-3){1'b0}}, timeout_o, done_o, busy_o};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
    end
  end

`ifdef RETIRE_MON_DUAL_CNT_EN
  logic [CNT_W-1:0] dual_q, dual_d;

  always_comb begin
    dual_d = dual_q;
    if (clr_cnt) dual_d = '0;
    else if (cnt_en && retire0_i && retire1_i && (dual_q != CNT_MAX)) dual_d = dual_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) dual_q <= '0;
    else        dual_q <= dual_d;
  end

  assign dual_cnt = dual_q;
`else
  assign dual_cnt = '0;
`endif

  assign cycle_cnt_o = cycle_q;
  assign instr_cnt_o = instr_q;
  assign rd_data_o   = rd_q;
  assign busy_o      = cnt_en;
  assign done_o      = (state_q == S_DONE);
  assign timeout_o   = (state_q == S_TIMEOUT);

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Directed bench for retire_perf_monitor: main instance (32-bit, drain 10, timeout 100) and a
// narrow instance (4-bit, drain 0) for saturation and direct RUN->DONE.
module tb_retire_perf_monitor;

`ifdef RETIRE_MON_DUAL_CNT_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start, r0, r1, csr;
  logic [1:0]  rd_sel;
  logic [31:0] rd_data, cyc, ins;
  logic        busy, done, tmo;

  logic        s_start, s_r0, s_r1, s_csr;
  logic [1:0]  s_rd_sel;
  logic [3:0]  s_rd, s_cyc, s_ins;
  logic        s_busy, s_done, s_tmo;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  retire_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(100)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start), .retire0_i(r0), .retire1_i(r1),
    .csr_wr_i(csr), .rd_sel_i(rd_sel), .rd_data_o(rd_data), .cycle_cnt_o(cyc),
    .instr_cnt_o(ins), .busy_o(busy), .done_o(done), .timeout_o(tmo)
  );

  retire_perf_monitor #(.CNT_W(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(100)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(s_start), .retire0_i(s_r0), .retire1_i(s_r1),
    .csr_wr_i(s_csr), .rd_sel_i(s_rd_sel), .rd_data_o(s_rd), .cycle_cnt_o(s_cyc),
    .instr_cnt_o(s_ins), .busy_o(s_busy), .done_o(s_done), .timeout_o(s_tmo)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    start = 1'b0; r0 = 1'b0; r1 = 1'b0; csr = 1'b0; rd_sel = 2'd0;
    s_start = 1'b0; s_r0 = 1'b0; s_r1 = 1'b0; s_csr = 1'b0; s_rd_sel = 2'd0;
    tick(1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_cyc", cyc, 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    rst_i = 1'b1;
    tick(1);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic run: 20 RUN cycles, retire1 in the first 5, csr on the 20th
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      r0 = 1'b1; r1 = (i < 5); csr = (i == 19);
      tick(1);
    end
    r0 = 1'b0; r1 = 1'b0; csr = 1'b0;
    chk("basic_cyc_at_csr", cyc, 32'd20);
    chk("basic_ins_at_csr", ins, 32'd25);
    chk("basic_busy", 32'(busy), 32'd1);
    r1 = 1'b1; tick(1); r1 = 1'b0;
    tick(8);
    chk("drain9_busy", 32'(busy), 32'd1);
    chk("drain9_done", 32'(done), 32'd0);
    tick(1);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_busy_off", 32'(busy), 32'd0);
    chk("basic_cyc", cyc, 32'd30);
    chk("basic_ins", ins, 32'd26);
    r0 = 1'b1; r1 = 1'b1; csr = 1'b1; tick(3);
    r0 = 1'b0; r1 = 1'b0; csr = 1'b0;
    chk("done_hold_cyc", cyc, 32'd30);
    chk("done_hold_ins", ins, 32'd26);
    chk("done_hold_done", 32'(done), 32'd1);

    // Readback in DONE
    rd_sel = 2'd3; tick(1);
    chk("rd_status", rd_data, 32'h2);
    rd_sel = 2'd1; tick(1);
    chk("rd_instr", rd_data, 32'd26);
    rd_sel = 2'd2; tick(1);
    chk("rd_dual", rd_data, DUAL ? 32'd5 : 32'd0);
    rd_sel = 2'd0; tick(1);
    chk("rd_cycle", rd_data, 32'd30);

    // csr on the cycle cycle_cnt == TIMEOUT_CYCLES-1; start mid-RUN ignored
    start = 1'b1; tick(1); start = 1'b0;
    chk("restart_cyc", cyc, 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 100; i++) begin
      r1 = (i < 3); start = (i == 50); csr = (i == 99);
      tick(1);
    end
    r1 = 1'b0; start = 1'b0; csr = 1'b0;
    chk("simul_cyc", cyc, 32'd100);
    chk("simul_ins", ins, 32'd3);
    chk("simul_tmo", 32'(tmo), 32'd0);
    chk("simul_busy", 32'(busy), 32'd1);
    tick(10);
    chk("simul_done", 32'(done), 32'd1);
    chk("simul_tmo_end", 32'(tmo), 32'd0);
    chk("simul_cyc_end", cyc, 32'd110);

    // Timeout
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 99; i++) begin
      r0 = (i < 7);
      tick(1);
    end
    r0 = 1'b0;
    chk("to_pre_tmo", 32'(tmo), 32'd0);
    chk("to_pre_cyc", cyc, 32'd99);
    tick(1);
    chk("to_tmo", 32'(tmo), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_cyc", cyc, 32'd100);
    chk("to_ins", ins, 32'd7);
    r0 = 1'b1; r1 = 1'b1; csr = 1'b1; tick(50);
    r0 = 1'b0; r1 = 1'b0; csr = 1'b0;
    chk("to_hold_cyc", cyc, 32'd100);
    chk("to_hold_ins", ins, 32'd7);
    chk("to_hold_tmo", 32'(tmo), 32'd1);
    rd_sel = 2'd3; tick(1);
    chk("to_rd_status", rd_data, 32'h4);

    // Reset mid-DRAIN
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r0 = 1'b1; csr = (i == 4);
      tick(1);
    end
    r0 = 1'b0; csr = 1'b0;
    tick(3);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_rd", rd_data, 32'h1);
    #2 rst_i = 1'b0; start = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_tmo", 32'(tmo), 32'd0);
    chk("arst_cyc", cyc, 32'd0);
    chk("arst_ins", ins, 32'd0);
    chk("arst_rd", rd_data, 32'd0);
    tick(1);
    rst_i = 1'b1; start = 1'b0;
    tick(2);
    chk("post_rst_idle", 32'(busy), 32'd0);
    chk("post_rst_cyc", cyc, 32'd0);
    start = 1'b1; tick(1); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r0 = 1'b1; r1 = 1'b1; csr = (i == 3);
      tick(1);
    end
    r0 = 1'b0; r1 = 1'b0; csr = 1'b0;
    chk("rerun_cyc", cyc, 32'd4);
    chk("rerun_ins", ins, 32'd8);
    chk("rerun_busy", 32'(busy), 32'd1);

    // Saturation on 4-bit counters, DRAIN_CYCLES=0 goes straight to DONE
    s_start = 1'b1; tick(1); s_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_r0 = 1'b1; s_r1 = 1'b1; s_csr = (i == 9);
      tick(1);
      if (i == 6) chk("sat_ins_14", 32'(s_ins), 32'd14);
    end
    s_r0 = 1'b0; s_r1 = 1'b0; s_csr = 1'b0;
    chk("sat_done", 32'(s_done), 32'd1);
    chk("sat_busy", 32'(s_busy), 32'd0);
    chk("sat_cyc", 32'(s_cyc), 32'd10);
    chk("sat_ins", 32'(s_ins), 32'd15);
    s_r0 = 1'b1; s_r1 = 1'b1; tick(3);
    s_r0 = 1'b0; s_r1 = 1'b0;
    chk("sat_hold_ins", 32'(s_ins), 32'd15);
    chk("sat_hold_cyc", 32'(s_cyc), 32'd10);
    chk("sat_tmo", 32'(s_tmo), 32'd0);
    s_rd_sel = 2'd2; tick(1);
    chk("sat_rd_dual", 32'(s_rd), DUAL ? 32'd10 : 32'd0);
    s_rd_sel = 2'd1; tick(1);
    chk("sat_rd_instr", 32'(s_rd), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
